// File: rtl/dvi_pkg.sv
// Shared types and helpers for the DVI timing controller: FSM states, encoder
// ctrl constants, raster total helper and the test-pattern bar colours.
package dvi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        RUN
    } dvi_state_e;

    localparam logic [1:0] CTRL_IDLE = 2'b00;

    function automatic int unsigned dvi_total(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        return a + b + c + d;
    endfunction

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] dvi_tpg_colour(input logic [2:0] bar);
        logic [23:0] c;
        case (bar)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvi_raster_counter.sv
// Horizontal/vertical raster counters with active/sync/origin flags and the
// frame-end stop request. Optional bar index output under DVI_TPG_EN.
module dvi_raster_counter
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic       i_en,
`ifdef DVI_TPG_EN
    output logic [2:0] o_bar,
`endif
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_origin,
    output logic       o_eol,
    output logic       o_stop
);

    localparam int unsigned H_TOTAL = dvi_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = dvi_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_last, v_last;

    always_comb begin
        h_last  = (32'(h_cnt_q) == H_TOTAL - 1);
        v_last  = (32'(v_cnt_q) == V_TOTAL - 1);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!i_run) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Comparisons are done at 32 bits so a zero back porch cannot wrap the bound.
    assign o_active = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    assign o_hsync  = (32'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                      (32'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    assign o_vsync  = (32'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                      (32'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
    assign o_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign o_eol    = (32'(h_cnt_q) == H_ACTIVE - 1);
    assign o_stop   = h_last && v_last && !i_en;

`ifdef DVI_TPG_EN
    assign o_bar = 3'((32'(h_cnt_q) * 32'd8) / H_ACTIVE);
`endif

endmodule

// File: rtl/dvi_video_timing_ctrl.sv
// DVI raster timing and pixel sequencing for the three TMDS encoders.
// Optional colour-bar test pattern when DVI_TPG_EN is defined.
module dvi_video_timing_ctrl
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
`ifdef DVI_TPG_EN
    input  logic        i_tpg,
`endif
    input  logic [23:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tuser,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [7:0]  o_data_r,
    output logic [7:0]  o_data_g,
    output logic [7:0]  o_data_b,
    output logic [1:0]  o_ctrl_b,
    output logic [1:0]  o_ctrl_g,
    output logic [1:0]  o_ctrl_r,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start,
    output logic        o_underflow,
    output logic        o_sync_err
);

    dvi_state_e  state_q, state_d;
    logic [23:0] data_q, data_d;
    logic        de_q, de_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        fs_q, fs_d;
    logic        uf_q, uf_d;
    logic        se_q, se_d;
    logic        ready;
    logic        running, tpg_now;
    logic        active, hsync, vsync, origin, eol, stop;
`ifdef DVI_TPG_EN
    logic        tpg_q, tpg_d;
    logic [2:0]  bar;
`endif

    assign running = (state_q != IDLE);

    dvi_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_raster (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_run    (running),
        .i_en     (i_en),
`ifdef DVI_TPG_EN
        .o_bar    (bar),
`endif
        .o_active (active),
        .o_hsync  (hsync),
        .o_vsync  (vsync),
        .o_origin (origin),
        .o_eol    (eol),
        .o_stop   (stop)
    );

    always_comb begin
        state_d = state_q;
        data_d  = '0;
        de_d    = 1'b0;
        hsync_d = ~H_POL;
        vsync_d = ~V_POL;
        fs_d    = 1'b0;
        uf_d    = 1'b0;
        se_d    = 1'b0;
        ready   = 1'b0;
`ifdef DVI_TPG_EN
        tpg_d   = tpg_q;
        if (running && origin) tpg_d = i_tpg;
        tpg_now = (running && origin) ? i_tpg : tpg_q;
`else
        tpg_now = 1'b0;
`endif

        if (running) begin
            de_d    = active;
            hsync_d = hsync ? H_POL : ~H_POL;
            vsync_d = vsync ? V_POL : ~V_POL;
        end

        if (running && tpg_now) begin
`ifdef DVI_TPG_EN
            if (active) data_d = dvi_tpg_colour(bar);
`endif
            fs_d = origin;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_en) state_d = SEEK;
                end
                // Non-SOF beats are drained; an SOF beat waits for the raster origin.
                SEEK: begin
                    ready = !s_tuser || origin;
                    if (origin && s_tvalid && s_tuser) begin
                        data_d  = s_tdata;
                        fs_d    = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    ready = active;
                    if (active) begin
                        if (!s_tvalid) begin
                            uf_d    = 1'b1;
                            state_d = SEEK;
                        end else begin
                            data_d = s_tdata;
                            fs_d   = origin;
                            if ((s_tuser && !origin) || (s_tlast != eol)) begin
                                se_d    = 1'b1;
                                state_d = SEEK;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (running && stop) state_d = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
            se_q    <= 1'b0;
`ifdef DVI_TPG_EN
            tpg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
            se_q    <= se_d;
`ifdef DVI_TPG_EN
            tpg_q   <= tpg_d;
`endif
        end
    end

    assign s_tready      = ready;
    assign o_data_r      = data_q[23:16];
    assign o_data_g      = data_q[15:8];
    assign o_data_b      = data_q[7:0];
    assign o_ctrl_b      = {vsync_q, hsync_q};
    assign o_ctrl_g      = CTRL_IDLE;
    assign o_ctrl_r      = CTRL_IDLE;
    assign o_de          = de_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_frame_start = fs_q;
    assign o_underflow   = uf_q;
    assign o_sync_err    = se_q;

endmodule

// File: tb/tb_dvi_video_timing_ctrl.sv
// Directed bench for dvi_video_timing_ctrl on a 7x5 raster (4x2 active).
module tb_dvi_video_timing_ctrl;

    localparam int HT = 7;
    localparam int VT = 5;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst, en, tvalid, tuser, tlast, tready;
    logic [23:0] tdata;
    logic [7:0]  dr, dg, db;
    logic [1:0]  cb, cg, cr;
    logic        de, hs, vs, fs, uf, se;
`ifdef DVI_TPG_EN
    logic        tpg = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;
    beat_t q[$];

    typedef struct {
        logic [6:0] de;
        logic [6:0] hs;
        logic       vs;
    } line_exp_t;
    line_exp_t lines[VT];

    // Per-frame stimulus and expected outcome.
    typedef struct {
        logic push;
        int   drop_k;
        int   err_p;
        int   en_off_k;
        int   black_from;
        int   uf_k;
        int   se_k;
        logic fs;
    } frame_vec_t;
    frame_vec_t vecs[8];

    always #5 clk = ~clk;

    dvi_video_timing_ctrl #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL (1'b0), .V_POL (1'b0)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
`ifdef DVI_TPG_EN
        .i_tpg         (tpg),
`endif
        .s_tdata       (tdata),
        .s_tvalid      (tvalid),
        .s_tuser       (tuser),
        .s_tlast       (tlast),
        .s_tready      (tready),
        .o_data_r      (dr),
        .o_data_g      (dg),
        .o_data_b      (db),
        .o_ctrl_b      (cb),
        .o_ctrl_g      (cg),
        .o_ctrl_r      (cr),
        .o_de          (de),
        .o_hsync       (hs),
        .o_vsync       (vs),
        .o_frame_start (fs),
        .o_underflow   (uf),
        .o_sync_err    (se)
    );

    function automatic logic [23:0] pix(input int f, input int v, input int h);
        logic [23:0] r;
        r = 24'hA00000 | 24'(f << 16) | 24'(v << 8) | 24'(h);
        return r;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " de"}, de, 0);
        chk({tag, " data"}, {dr, dg, db}, 0);
        chk({tag, " hsync"}, hs, 1);
        chk({tag, " vsync"}, vs, 1);
        chk({tag, " ctrl_b"}, cb, 2'b11);
        chk({tag, " ctrl_g"}, cg, 0);
        chk({tag, " ctrl_r"}, cr, 0);
        chk({tag, " fs"}, fs, 0);
        chk({tag, " uf"}, uf, 0);
        chk({tag, " se"}, se, 0);
    endtask

    task automatic push_frame(input int f, input int err_p);
        beat_t b;
        for (int p = 0; p < 8; p++) begin
            b.d = pix(f, p / 4, p % 4);
            b.u = (p == 0);
            b.l = (p % 4 == 3) || (p == err_p);
            q.push_back(b);
        end
    endtask

    // One clock: present queue head, capture handshake, pop on accept, settle past the edge.
    task automatic drive_cycle(input logic drop, output logic rdy);
        logic acc;
        if (q.size() > 0 && !drop) begin
            tvalid = 1'b1;
            tdata  = q[0].d;
            tuser  = q[0].u;
            tlast  = q[0].l;
        end else begin
            tvalid = 1'b0;
            tdata  = '0;
            tuser  = 1'b0;
            tlast  = 1'b0;
        end
        #1;
        rdy = tready;
        acc = tvalid && tready;
        @(posedge clk);
        if (acc) q.delete(0);
        #1;
    endtask

    task automatic check_pos(input int f, input int k, input frame_vec_t fv);
        int h, v;
        logic de_e, hs_e, vs_e;
        logic [23:0] d_e;
        string t;
        h = k % HT;
        v = k / HT;
        de_e = lines[v].de[h];
        hs_e = lines[v].hs[h];
        vs_e = lines[v].vs;
        d_e = (de_e && k < fv.black_from) ? pix(f, v, h) : 24'h0;
        t = $sformatf("f%0d k%0d", f, k);
        chk({t, " de"}, de, de_e);
        chk({t, " data"}, {dr, dg, db}, d_e);
        chk({t, " hsync"}, hs, hs_e);
        chk({t, " vsync"}, vs, vs_e);
        chk({t, " ctrl_b"}, cb, {vs_e, hs_e});
        chk({t, " fs"}, fs, fv.fs && k == 0);
        chk({t, " uf"}, uf, k == fv.uf_k);
        chk({t, " se"}, se, k == fv.se_k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy;
        beat_t b;
        frame_vec_t nv;

        lines[0] = '{7'b0001111, 7'b1011111, 1'b1};
        lines[1] = '{7'b0001111, 7'b1011111, 1'b1};
        lines[2] = '{7'b0000000, 7'b1011111, 1'b1};
        lines[3] = '{7'b0000000, 7'b1011111, 1'b0};
        lines[4] = '{7'b0000000, 7'b1011111, 1'b1};

        //          push  drop  err_p en_off black uf    se    fs
        vecs[0] = '{1'b0, -1,   -1,   -1,    0,    -1,   -1,   1'b0};
        vecs[1] = '{1'b0, -1,   -1,   -1,    99,   -1,   -1,   1'b1};
        vecs[2] = '{1'b1, -1,   -1,   -1,    99,   -1,   -1,   1'b1};
        vecs[3] = '{1'b1, 9,    -1,   -1,    9,    9,    -1,   1'b1};
        vecs[4] = '{1'b1, -1,   -1,   -1,    99,   -1,   -1,   1'b1};
        vecs[5] = '{1'b1, -1,   2,    -1,    3,    -1,   2,    1'b1};
        vecs[6] = '{1'b1, -1,   -1,   -1,    99,   -1,   -1,   1'b1};
        vecs[7] = '{1'b1, -1,   -1,   10,    99,   -1,   -1,   1'b1};
        nv      = '{1'b1, -1,   -1,   -1,    99,   -1,   -1,   1'b1};

        rst = 1'b1; en = 1'b0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        chk("reset tready", tready, 0);
        rst = 1'b0;

        // Three junk beats ahead of the first frame; IDLE must not take any.
        for (int i = 0; i < 3; i++) begin
            b.d = 24'h5A5A00 | 24'(i);
            b.u = 1'b0;
            b.l = 1'b0;
            q.push_back(b);
        end
        push_frame(1, -1);
        drive_cycle(1'b0, rdy);
        chk("idle tready", rdy, 0);
        check_reset("idle");
        en = 1'b1;
        drive_cycle(1'b0, rdy);
        chk("enable tready", rdy, 0);
        check_reset("enable edge");

        for (int f = 0; f < 8; f++) begin
            if (vecs[f].push) push_frame(f, vecs[f].err_p);
            for (int k = 0; k < FRAME; k++) begin
                if (k == vecs[f].en_off_k) en = 1'b0;
                drive_cycle(k == vecs[f].drop_k, rdy);
                if (f == 0 && k < 4) chk($sformatf("seek tready k%0d", k), rdy, k < 3);
                check_pos(f, k, vecs[f]);
            end
            if (f == 0) chk("junk drained sof held", 24'(q.size()), 8);
        end

        // Enable was dropped during the last frame: now parked in IDLE.
        push_frame(9, -1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, rdy);
            chk($sformatf("post-en idle tready %0d", i), rdy, 0);
            check_reset($sformatf("post-en idle %0d", i));
        end
        chk("idle holds beats", 24'(q.size()), 8);

        // Restart, then reset in the middle of an active line.
        en = 1'b1;
        drive_cycle(1'b0, rdy);
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1'b0, rdy);
            check_pos(9, k, nv);
        end
        rst = 1'b1;
        drive_cycle(1'b0, rdy);
        check_reset("midline reset");
        chk("midline reset tready", tready, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvi_video_timing_ctrl.md
Name: dvi_video_timing_ctrl

Overview:
Sequences the three per-channel TMDS encoders of the DVI output. Generates the horizontal and vertical raster timing. Pulls 24-bit RGB pixels from an upstream valid/ready stream, with SOF on tuser and EOL on tlast. Drives each encoder's data, ctrl and DE inputs cycle-aligned: blue ctrl = {vsync, hsync}, green/red ctrl = 2'b00. Sits between the frame-buffer/video pipeline and the three encoder instances in the pixel-clock domain.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active low)
V_POL, 0, vsync asserted level (0 = active low)

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  synchronous reset, active high
i_en  in  1  timing run enable
s_tdata  in  24  pixel {R[23:16],G[15:8],B[7:0]}
s_tvalid  in  1  pixel valid
s_tuser  in  1  start of frame, first pixel
s_tlast  in  1  end of line, last pixel of line
s_tready  out  1  pixel accept
o_data_r / o_data_g / o_data_b  out  8 each  encoder colour data
o_ctrl_b  out  2  blue encoder ctrl {vsync,hsync}
o_ctrl_g / o_ctrl_r  out  2 each  constant 2'b00
o_de  out  1  display enable, shared by all three encoders
o_hsync / o_vsync  out  1 each  sync at configured polarity (debug/VGA)
o_frame_start  out  1  one-cycle pulse on first active pixel
o_underflow  out  1  one-cycle pulse when a pixel was needed and s_tvalid=0
o_sync_err  out  1  one-cycle pulse on SOF/EOL misplacement

Behaviour:
- Clock i_clk; reset i_rst, synchronous, active-high.
- H_TOTAL = sum of H params; V_TOTAL = sum of V params. Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, width $clog2(TOTAL). h wraps to 0 and v increments; v wraps to 0 after V_TOTAL-1.
- Raster order: active, FP, sync, BP. hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt for the whole line. active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- All outputs except s_tready are registered. Latency is 1 clock from counter state to encoder inputs. data, de and ctrl change on the same edge.
- Reset and IDLE values: counters 0; o_de=0; data 0; syncs deasserted (o_hsync=~H_POL, o_vsync=~V_POL, o_ctrl_b={~V_POL,~H_POL}); pulses 0; state IDLE.
- FSM states:
  - IDLE: i_en=0. Counters held at 0, s_tready=0. i_en=1 -> SEEK.
  - SEEK: timing runs and output pixels are black. s_tready=1 while the head beat is not SOF, discarding the beat. On an SOF head beat, s_tready=0 and the beat is held until h=0,v=0. At h=0,v=0 with s_tvalid&&s_tuser, the beat is consumed as pixel (0,0), o_frame_start pulses, and the FSM goes to RUN.
  - RUN: s_tready=active (combinational).
    - active && !s_tvalid: output black for that pixel, o_underflow pulse, go to SEEK; rest of frame black.
    - Accepted beat with tuser=1 where (h,v)!=(0,0), or tlast != (h_cnt==H_ACTIVE-1): o_sync_err pulse; beat is still displayed; go to SEEK.
- i_en deassert goes to IDLE only at frame end (h,v = last), so the frame completes. i_rst mid-frame acts immediately and returns everything to reset values.
- Blanking data is 0. The encoders own DC bias reset via de=0.

Optional Feature:
DVI_TPG_EN: when defined, adds input i_tpg (1 bit). With i_tpg=1, s_tready=0 and active pixels are an 8-bar colour pattern: bar = h_cnt*8/H_ACTIVE, each colour bit = 8'hFF, bar order white, yellow, cyan, green, magenta, red, blue, black. Underflow and sync_err pulses are suppressed. i_tpg is sampled at frame start only. When undefined, the port and logic are absent.

Decomposition:
- Package dvi_pkg: state enum (IDLE/SEEK/RUN), ctrl constants CTRL_IDLE = 2'b00, a totals helper function, and the TPG bar colour table.
- Sub-module dvi_raster_counter: h/v counters, wrap logic, active/hsync/vsync/frame_last flags, and enable-at-frame-end handling.

Test Plan:
- Small timing (H 4/1/1/1, V 2/1/1/1, POL 0), continuous valid stream with correct SOF/EOL -> hsync low at h=5 each line; vsync low on line 3; o_de high 4 clk per active line; data equals input with 1-clk latency.
- 3 non-SOF junk beats before SOF -> junk discarded; SOF beat displayed at (0,0); o_frame_start single pulse.
- s_tvalid dropped at pixel (2,1) -> that pixel 0x000000, o_underflow 1 pulse, remainder of frame black, resync and normal output next frame.
- tlast at h=2 instead of 3 -> o_sync_err pulse; SEEK; next frame clean.
- i_en dropped mid-frame -> frame completes, then IDLE with s_tready=0; i_rst asserted mid-line -> next cycle all outputs at reset values.
- (DVI_TPG_EN) i_tpg=1, H_ACTIVE=8 -> pixel 0 = FFFFFF, pixel 1 = FFFF00, pixel 7 = 000000; s_tready=0.
